prim_unpacker_strb: RTL and testbench

- Width down-converter. Accepts one wide word per handshake, together with a per-chunk strobe and a last flag.
- Emits only the strobed OutW-wide chunks, in ascending chunk order, over a narrow valid/ready interface.
- Sits on the producer-facing side of narrow serial peripherals (TX FIFOs, SPI/UART data paths). It is the counterpart of the packing FIFO that assembles narrow beats into wide words, and it adds sparse (masked) words plus end-of-packet marking.

---
 rtl/prim_unpacker_strb.sv | 106 ++++++++++
 tb/tb_prim_unpacker_strb.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/prim_unpacker_strb.sv
// prim_unpacker_strb: strobed wide-to-narrow unpacker emitting masked chunks in ascending order.
// Define PRIM_UNPACKER_STRB_OUT_REG_EN to register the selected chunk (latency 2, full throughput).
module prim_unpacker_strb #(
  parameter int InW = 32,
  parameter int OutW = 8,
  parameter bit ClearOnRead = 1'b1,
  localparam int N = InW / OutW,
  localparam int CntW = $clog2(N + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            wvalid_i,
  input  logic [InW-1:0]  wdata_i,
  input  logic [N-1:0]    wmask_i,
  input  logic            wlast_i,
  output logic            wready_o,
  output logic            rvalid_o,
  output logic [OutW-1:0] rdata_o,
  output logic            rlast_o,
  input  logic            rready_i,
  output logic [CntW-1:0] depth_o
);
  localparam int IdxW = N > 1 ? $clog2(N) : 1;

  if (InW % OutW != 0) begin : g_bad_width
    $error("InW must be an integer multiple of OutW");
  end

  logic [InW-1:0]  data_q;
  logic [N-1:0]    mask_q, mask_pull;
  logic            last_q, clr_q;
  logic [IdxW-1:0] idx;
  logic [OutW-1:0] pick;
  logic [CntW-1:0] cnt;
  logic            sel_last, avail, pull, accept;

  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) if (mask_q[k]) idx = IdxW'(k);
  end

  assign pick      = data_q[idx*OutW +: OutW];
  assign cnt       = CntW'($countones(mask_q));
  assign mask_pull = mask_q & ~(N'(1) << idx);
  assign avail     = (mask_q != '0) && !clr_q;
  assign sel_last  = last_q && (cnt == CntW'(1));
  // A new word may land on the same edge the final held chunk leaves.
  assign wready_o  = !clr_q && ((mask_q == '0) || (pull && cnt == CntW'(1)));
  assign accept    = wvalid_i && wready_o;

`ifdef PRIM_UNPACKER_STRB_OUT_REG_EN
  logic            ov_q, ol_q;
  logic [OutW-1:0] od_q;
  assign pull     = avail && (!ov_q || rready_i);
  assign rvalid_o = ov_q;
  assign rdata_o  = (ClearOnRead && !ov_q) ? '0 : od_q;
  assign rlast_o  = (ClearOnRead && !ov_q) ? 1'b0 : ol_q;
  assign depth_o  = cnt + CntW'(ov_q);
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      ov_q <= 1'b0;
      od_q <= '0;
      ol_q <= 1'b0;
    end else if (pull) begin
      ov_q <= 1'b1;
      od_q <= pick;
      ol_q <= sel_last;
    end else if (rready_i) begin
      ov_q <= 1'b0;
    end
  end
`else
  assign pull     = avail && rready_i;
  assign rvalid_o = avail;
  assign rdata_o  = (ClearOnRead && !avail) ? '0 : pick;
  assign rlast_o  = (ClearOnRead && !avail) ? 1'b0 : sel_last;
  assign depth_o  = cnt;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      data_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      clr_q  <= 1'b1;
    end else begin
      clr_q <= 1'b0;
      if (accept) begin
        data_q <= wdata_i;
        mask_q <= wmask_i;
        last_q <= wlast_i;
      end else if (pull) begin
        mask_q <= mask_pull;
      end
    end
  end

  a_hold: assert property (@(posedge clk_i)
    rst_ni && rvalid_o && !rready_i && !clr_i |=> rvalid_o && $stable(rdata_o) && $stable(rlast_o));

  // An empty-mask word carries no beat, so its end-of-packet marker is lost.
  a_last_empty: assert property (@(posedge clk_i)
    rst_ni && !clr_i && accept && wlast_i |-> wmask_i != '0)
    else $warning("wlast_i accepted with empty wmask_i: packet end dropped");
endmodule

// File: tb/tb_prim_unpacker_strb.sv
// tb_prim_unpacker_strb: directed self-checking bench for the default (combinational output) build.
module tb_prim_unpacker_strb;
  logic        clk = 1'b0;
  logic        rst_n, clr, wvalid, wlast, wready, rvalid, rlast, rready;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [7:0]  rdata;
  logic [2:0]  depth;
  int checks = 0;
  int failures = 0;

  prim_unpacker_strb dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wvalid_i(wvalid), .wdata_i(wdata),
    .wmask_i(wmask), .wlast_i(wlast), .wready_o(wready), .rvalid_o(rvalid),
    .rdata_o(rdata), .rlast_o(rlast), .rready_i(rready), .depth_o(depth)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; wvalid = 1'b0; wdata = '0; wmask = '0; wlast = 1'b0; rready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    checks++; if (rlast !== 1'b0) begin failures++; $display("FAIL reset_rlast got=%b exp=0", rlast); end
    checks++; if (depth !== 3'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", depth); end
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL reset_wready got=%b exp=0", wready); end
  endtask

  task automatic test_full_word;
    logic [7:0] exp_d [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    @(negedge clk);
    rst_n = 1'b1; wvalid = 1'b1; wdata = 32'hDDCCBBAA; wmask = 4'b1111; wlast = 1'b1; rready = 1'b1;
    #1;
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL release_wready got=%b exp=0", wready); end
    @(negedge clk); #1;
    checks++; if (wready !== 1'b1) begin failures++; $display("FAIL full_wready got=%b exp=1", wready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wvalid = 1'b0;
      #1;
      checks++; if (rvalid !== 1'b1 || rdata !== exp_d[i]) begin failures++; $display("FAIL full_beat%0d got=%b/%h exp=1/%h", i, rvalid, rdata, exp_d[i]); end
      checks++; if (depth !== 3'(4 - i)) begin failures++; $display("FAIL full_depth%0d got=%0d exp=%0d", i, depth, 4 - i); end
      checks++; if (rlast !== (i == 3)) begin failures++; $display("FAIL full_rlast%0d got=%b exp=%b", i, rlast, i == 3); end
    end
    @(negedge clk); #1;
    checks++; if (rvalid !== 1'b0 || depth !== 3'd0) begin failures++; $display("FAIL full_drain got=%b/%0d exp=0/0", rvalid, depth); end
  endtask

  task automatic test_sparse;
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'hDDCCBBAA; wmask = 4'b1010; wlast = 1'b1;
    #1;
    checks++; if (wready !== 1'b1) begin failures++; $display("FAIL sparse_wready got=%b exp=1", wready); end
    @(negedge clk);
    wvalid = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b1 || rdata !== 8'hBB || depth !== 3'd2 || rlast !== 1'b0) begin failures++; $display("FAIL sparse_b0 got=%b/%h/%0d/%b exp=1/bb/2/0", rvalid, rdata, depth, rlast); end
    @(negedge clk); #1;
    checks++; if (rvalid !== 1'b1 || rdata !== 8'hDD || depth !== 3'd1 || rlast !== 1'b1) begin failures++; $display("FAIL sparse_b1 got=%b/%h/%0d/%b exp=1/dd/1/1", rvalid, rdata, depth, rlast); end
    @(negedge clk); #1;
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL sparse_end got=%b exp=0", rvalid); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'h03020100; wmask = 4'b1111; wlast = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin wdata = 32'h07060504; wlast = 1'b1; end
      if (i == 4) wvalid = 1'b0;
      #1;
      checks++; if (rvalid !== 1'b1 || rdata !== 8'(i)) begin failures++; $display("FAIL b2b_beat%0d got=%b/%h exp=1/%h", i, rvalid, rdata, 8'(i)); end
      checks++; if (depth !== 3'(i < 4 ? 4 - i : 8 - i) || rlast !== (i == 7)) begin failures++; $display("FAIL b2b_meta%0d got=%0d/%b exp=%0d/%b", i, depth, rlast, i < 4 ? 4 - i : 8 - i, i == 7); end
      if (i == 3) begin
        checks++; if (wready !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", wready); end
      end
    end
    @(negedge clk); #1;
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", rvalid); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'hDDCCBBAA; wmask = 4'b1111; wlast = 1'b0; rready = 1'b1;
    @(negedge clk); wvalid = 1'b0; #1;
    checks++; if (rdata !== 8'hAA) begin failures++; $display("FAIL bp_aa got=%h exp=aa", rdata); end
    @(negedge clk); #1;
    checks++; if (rdata !== 8'hBB) begin failures++; $display("FAIL bp_bb got=%h exp=bb", rdata); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rready = 1'b0;
      #1;
      checks++; if (rvalid !== 1'b1 || rdata !== 8'hCC || wready !== 1'b0 || depth !== 3'd2) begin failures++; $display("FAIL bp_stall%0d got=%b/%h/%b/%0d exp=1/cc/0/2", i, rvalid, rdata, wready, depth); end
    end
    @(negedge clk); rready = 1'b1; #1;
    checks++; if (rvalid !== 1'b1 || rdata !== 8'hCC) begin failures++; $display("FAIL bp_release got=%b/%h exp=1/cc", rvalid, rdata); end
    @(negedge clk); #1;
    checks++; if (rvalid !== 1'b1 || rdata !== 8'hDD || depth !== 3'd1) begin failures++; $display("FAIL bp_dd got=%b/%h/%0d exp=1/dd/1", rvalid, rdata, depth); end
    @(negedge clk); #1;
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL bp_end got=%b exp=0", rvalid); end
  endtask

  task automatic test_clear;
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'hDDCCBBAA; wmask = 4'b1111; wlast = 1'b1; rready = 1'b1;
    @(negedge clk); wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk); clr = 1'b1; #1;
    checks++; if (depth !== 3'd2 || rdata !== 8'hCC) begin failures++; $display("FAIL clr_pre got=%0d/%h exp=2/cc", depth, rdata); end
    @(negedge clk); clr = 1'b0; #1;
    checks++; if (rvalid !== 1'b0 || wready !== 1'b0 || depth !== 3'd0 || rdata !== 8'h00) begin failures++; $display("FAIL clr_post got=%b/%b/%0d/%h exp=0/0/0/00", rvalid, wready, depth, rdata); end
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'h44332211; wmask = 4'b0011; wlast = 1'b1;
    #1;
    checks++; if (wready !== 1'b1) begin failures++; $display("FAIL clr_wready got=%b exp=1", wready); end
    @(negedge clk); wvalid = 1'b0; #1;
    checks++; if (rvalid !== 1'b1 || rdata !== 8'h11 || depth !== 3'd2 || rlast !== 1'b0) begin failures++; $display("FAIL clr_new0 got=%b/%h/%0d/%b exp=1/11/2/0", rvalid, rdata, depth, rlast); end
    @(negedge clk); #1;
    checks++; if (rvalid !== 1'b1 || rdata !== 8'h22 || rlast !== 1'b1) begin failures++; $display("FAIL clr_new1 got=%b/%h/%b exp=1/22/1", rvalid, rdata, rlast); end
  endtask

  task automatic test_reset_zero_mask;
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'hDDCCBBAA; wmask = 4'b1111; wlast = 1'b1; rready = 1'b1;
    @(negedge clk); wvalid = 1'b0; #1;
    checks++; if (rdata !== 8'hAA) begin failures++; $display("FAIL mid_pre got=%h exp=aa", rdata); end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (rvalid !== 1'b0 || rdata !== 8'h00 || rlast !== 1'b0 || depth !== 3'd0 || wready !== 1'b0) begin failures++; $display("FAIL mid_reset got=%b/%h/%b/%0d/%b exp=0/00/0/0/0", rvalid, rdata, rlast, depth, wready); end
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'h12345678; wmask = 4'b0000; wlast = 1'b1;
    #1;
    checks++; if (wready !== 1'b1) begin failures++; $display("FAIL zero_wready got=%b exp=1", wready); end
    @(negedge clk); wvalid = 1'b0; wlast = 1'b0; #1;
    checks++; if (rvalid !== 1'b0 || depth !== 3'd0 || wready !== 1'b1) begin failures++; $display("FAIL zero_after got=%b/%0d/%b exp=0/0/1", rvalid, depth, wready); end
    @(negedge clk); #1;
    checks++; if (rvalid !== 1'b0 || rdata !== 8'h00) begin failures++; $display("FAIL zero_idle got=%b/%h exp=0/00", rvalid, rdata); end
  endtask

  initial begin
    test_reset;
    test_full_word;
    test_sparse;
    test_back_to_back;
    test_backpressure;
    test_clear;
    test_reset_zero_mask;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
